// File: rtl/wb_register_file_if.sv
// ---------------------------------------------------------------------------
// wb_register_file_if
//   Bundles the writeback-commit inputs, the decode-read port and the
//   debug/trace outputs of the architectural register file.
//
//   Parameters
//     XLEN   data width of registers and of the read/write ports
//     NREG   number of registers (address width = $clog2(NREG))
//     CNT_W  width of the committed-write counter
//
//   Signals
//     regFileWe_WB      writeback enable from the WriteBack cycle
//     instrCode_WB      WB instruction, rd = [11:7]
//     RFWDSrcMuxOut_WB  writeback data
//     instrCode_ID      decode instruction, rs1 = [19:15], rs2 = [24:20]
//     RFData1_ID        combinational read data for rs1
//     RFData2_ID        combinational read data for rs2
//     wbCount           committed writes since reset (wraps)
//     lastWbAddr        rd of the most recent committed write
//     lastWbData        data of the most recent committed write
//
//   Modports
//     master  pipeline side: drives WB/ID inputs, observes read/trace data
//     slave   register file side
// ---------------------------------------------------------------------------
interface wb_register_file_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 32
);
    localparam int AW = $clog2(NREG);

    logic              regFileWe_WB;
    logic [31:0]       instrCode_WB;
    logic [XLEN-1:0]   RFWDSrcMuxOut_WB;
    logic [31:0]       instrCode_ID;
    logic [XLEN-1:0]   RFData1_ID;
    logic [XLEN-1:0]   RFData2_ID;
    logic [CNT_W-1:0]  wbCount;
    logic [AW-1:0]     lastWbAddr;
    logic [XLEN-1:0]   lastWbData;

    modport master (
        output regFileWe_WB, instrCode_WB, RFWDSrcMuxOut_WB, instrCode_ID,
        input  RFData1_ID, RFData2_ID, wbCount, lastWbAddr, lastWbData
    );

    modport slave (
        input  regFileWe_WB, instrCode_WB, RFWDSrcMuxOut_WB, instrCode_ID,
        output RFData1_ID, RFData2_ID, wbCount, lastWbAddr, lastWbData
    );
endinterface

// File: rtl/wb_register_file.sv
// ---------------------------------------------------------------------------
// wb_register_file
//   Architectural register file at the receiving end of the writeback path.
//   Commits WriteBack-cycle results (we=1, rd!=0) on the rising clock edge,
//   serves two combinational read ports to Decode, and keeps a wrapping
//   committed-write counter plus a last-write record for debug/trace.
//   x0 reads as zero and is never written.
//
//   Ports
//     clk    pipeline clock, all state updates on posedge
//     reset  asynchronous, active-low reset
//     bus    wb_register_file_if.slave (WB commit, ID reads, trace outputs)
//
//   Configuration macro
//     REGFILE_BYPASS_EN  when defined, a committing write whose rd matches
//                        rs1/rs2 is forwarded to that read port in the same
//                        cycle. When undefined, reads see stored contents
//                        only and decode must stall one extra cycle on a
//                        same-cycle WB/ID match.
// ---------------------------------------------------------------------------
module wb_register_file #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    wb_register_file_if.slave    bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]  regs [NREG];
    logic [CNT_W-1:0] wb_count;
    logic [AW-1:0]    last_addr;
    logic [XLEN-1:0]  last_data;

    logic [AW-1:0]    rd;
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic             commit;

    assign rd  = bus.instrCode_WB[7 +: AW];
    assign rs1 = bus.instrCode_ID[15 +: AW];
    assign rs2 = bus.instrCode_ID[20 +: AW];

    // Gating with reset also blocks same-cycle forwarding while in reset.
    assign commit = reset && bus.regFileWe_WB && (rd != '0);

    // Instruction fields outside rd/rs1/rs2 are irrelevant here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.instrCode_WB[31:7+AW], bus.instrCode_WB[6:0],
                                 bus.instrCode_ID[31:20+AW], bus.instrCode_ID[14:0]};

    // NOTE: the register array is reset like any other state because the
    // architecture requires every register to read 0 after reset; this costs
    // reset fan-out to every entry instead of allowing a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            wb_count  <= '0;
            last_addr <= '0;
            last_data <= '0;
        end else if (commit) begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values, independent of statement order.
            regs[rd]  <= bus.RFWDSrcMuxOut_WB;
            wb_count  <= wb_count + CNT_W'(1);
            last_addr <= rd;
            last_data <= bus.RFWDSrcMuxOut_WB;
        end
    end

    // NOTE: blocking assignments with a default first keep this block purely
    // combinational; a missing default on any path would infer a latch.
    always_comb begin
        bus.RFData1_ID = (rs1 == '0) ? '0 : regs[rs1];
        bus.RFData2_ID = (rs2 == '0) ? '0 : regs[rs2];
`ifdef REGFILE_BYPASS_EN
        // commit implies rd!=0, so a match never forwards onto x0.
        if (commit && (rs1 == rd)) bus.RFData1_ID = bus.RFWDSrcMuxOut_WB;
        if (commit && (rs2 == rd)) bus.RFData2_ID = bus.RFWDSrcMuxOut_WB;
`endif
    end

    assign bus.wbCount    = wb_count;
    assign bus.lastWbAddr = last_addr;
    assign bus.lastWbData = last_data;
endmodule

// File: tb/tb_wb_register_file.sv
// ---------------------------------------------------------------------------
// tb_wb_register_file
//   Self-checking bench for wb_register_file. A default-width instance is
//   driven by directed vectors; a second instance with CNT_W=4 shares the
//   same stimulus so counter wrap can be observed.
// ---------------------------------------------------------------------------
module tb_wb_register_file;
    logic clk;
    logic reset;

    int n_vec;
    int n_err;

    wb_register_file_if #(.XLEN(32), .NREG(32), .CNT_W(32)) bus ();
    wb_register_file_if #(.XLEN(32), .NREG(32), .CNT_W(4))  bus4 ();

    wb_register_file #(.XLEN(32), .NREG(32), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    wb_register_file #(.XLEN(32), .NREG(32), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    assign bus4.regFileWe_WB     = bus.regFileWe_WB;
    assign bus4.instrCode_WB     = bus.instrCode_WB;
    assign bus4.RFWDSrcMuxOut_WB = bus.RFWDSrcMuxOut_WB;
    assign bus4.instrCode_ID     = bus.instrCode_ID;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #90000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp1;     // read port 1 before the edge
        logic [31:0] exp2;     // read port 2 before the edge
        logic [31:0] exp_cnt;  // after the edge
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        bus.regFileWe_WB     = we;
        bus.instrCode_WB     = {20'h00000, rd, 7'b0110011};
        bus.RFWDSrcMuxOut_WB = d;
        bus.instrCode_ID     = {7'b0000000, rs2, rs1, 3'b000, 5'b00000, 7'b0110011};
    endtask

    vec_t vecs [11];

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);

        //            we  rd     wdata          rs1    rs2    exp1           exp2           cnt    addr   data
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,         32'h0,         32'd1, 5'd5,  32'hDEADBEEF};
        vecs[1]  = '{1'b0, 5'd0,  32'h00000000, 5'd5,  5'd5,  32'hDEADBEEF,  32'hDEADBEEF,  32'd1, 5'd5,  32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,         32'h0,         32'd1, 5'd5,  32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'd0,  32'h00000000, 5'd0,  5'd5,  32'h0,         32'hDEADBEEF,  32'd1, 5'd5,  32'hDEADBEEF};
        vecs[4]  = '{1'b1, 5'd9,  32'h00000042, 5'd5,  5'd0,  32'hDEADBEEF,  32'h0,         32'd2, 5'd9,  32'h00000042};
        vecs[5]  = '{1'b0, 5'd9,  32'hFFFFFFFF, 5'd9,  5'd5,  32'h00000042,  32'hDEADBEEF,  32'd2, 5'd9,  32'h00000042};
        vecs[6]  = '{1'b0, 5'd0,  32'h00000000, 5'd9,  5'd9,  32'h00000042,  32'h00000042,  32'd2, 5'd9,  32'h00000042};
        vecs[7]  = '{1'b1, 5'd31, 32'h80000001, 5'd9,  5'd0,  32'h00000042,  32'h0,         32'd3, 5'd31, 32'h80000001};
        vecs[8]  = '{1'b1, 5'd7,  32'h00000011, 5'd31, 5'd5,  32'h80000001,  32'hDEADBEEF,  32'd4, 5'd7,  32'h00000011};
        vecs[9]  = '{1'b1, 5'd1,  32'hFFFFFFFF, 5'd7,  5'd31, 32'h00000011,  32'h80000001,  32'd5, 5'd1,  32'hFFFFFFFF};
        vecs[10] = '{1'b0, 5'd0,  32'h00000000, 5'd1,  5'd7,  32'hFFFFFFFF,  32'h00000011,  32'd5, 5'd1,  32'hFFFFFFFF};

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("reset rd1", bus.RFData1_ID, 32'h0);
        check("reset wbCount", bus.wbCount, 32'h0);
        check("reset lastWbAddr", {27'h0, bus.lastWbAddr}, 32'h0);
        check("reset lastWbData", bus.lastWbData, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // ---- table-driven vectors ----
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].rd, vecs[i].wdata, vecs[i].rs1, vecs[i].rs2);
            #1;
            check($sformatf("v%0d rd1", i), bus.RFData1_ID, vecs[i].exp1);
            check($sformatf("v%0d rd2", i), bus.RFData2_ID, vecs[i].exp2);
            @(posedge clk);
            #1;
            check($sformatf("v%0d wbCount", i), bus.wbCount, vecs[i].exp_cnt);
            check($sformatf("v%0d wbCount4", i), {28'h0, bus4.wbCount}, vecs[i].exp_cnt & 32'hF);
            check($sformatf("v%0d lastWbAddr", i), {27'h0, bus.lastWbAddr}, {27'h0, vecs[i].exp_addr});
            check($sformatf("v%0d lastWbData", i), bus.lastWbData, vecs[i].exp_data);
        end

        // ---- same-cycle WB/ID match on rs2 (reg[7] holds 0x11) ----
        @(negedge clk);
        drive(1'b1, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd7);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("match same-cycle rd2", bus.RFData2_ID, 32'hA5A5A5A5);
`else
        check("match same-cycle rd2", bus.RFData2_ID, 32'h00000011);
`endif
        check("match same-cycle rd1", bus.RFData1_ID, 32'h0);
        @(posedge clk);
        #1;
        check("match wbCount", bus.wbCount, 32'd6);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd7);
        #1;
        check("match next-cycle rd2", bus.RFData2_ID, 32'hA5A5A5A5);

        // ---- fill x1..x31 with own index, then read back ----
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            drive(1'b1, 5'(r), 32'(r), 5'd0, 5'd0);
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int r = 1; r < 32; r += 6) begin
            drive(1'b0, 5'd0, 32'h0, 5'(r), 5'(32 - r));
            #1;
            check($sformatf("fill rd1 x%0d", r), bus.RFData1_ID, 32'(r));
            check($sformatf("fill rd2 x%0d", 32 - r), bus.RFData2_ID, 32'(32 - r));
        end
        check("fill wbCount", bus.wbCount, 32'd37);
        check("fill wbCount4", {28'h0, bus4.wbCount}, 32'd5);

        // ---- async reset between edges, with a write in flight ----
        @(negedge clk);
        drive(1'b1, 5'd12, 32'h0000CAFE, 5'd12, 5'd31);
        #2;
        reset = 1'b0;
        #1;
        check("async rst rd1", bus.RFData1_ID, 32'h0);
        check("async rst rd2", bus.RFData2_ID, 32'h0);
        check("async rst wbCount", bus.wbCount, 32'h0);
        check("async rst lastWbAddr", {27'h0, bus.lastWbAddr}, 32'h0);
        check("async rst lastWbData", bus.lastWbData, 32'h0);
        @(posedge clk);
        #1;
        check("rst-low write rd1", bus.RFData1_ID, 32'h0);
        check("rst-low write wbCount", bus.wbCount, 32'h0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd12, 5'd31);
        reset = 1'b1;
        #1;
        check("post rst x12", bus.RFData1_ID, 32'h0);
        check("post rst x31", bus.RFData2_ID, 32'h0);
        check("post rst lastWbAddr", {27'h0, bus.lastWbAddr}, 32'h0);

        // ---- counter wrap: 17 commits to rd=3; the narrow counter wraps ----
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            drive(1'b1, 5'd3, 32'(k), 5'd0, 5'd0);
            @(posedge clk);
            #1;
            check($sformatf("wrap%0d wbCount4", k), {28'h0, bus4.wbCount}, 32'(k % 16));
            if (k >= 15) begin
                check($sformatf("wrap%0d wbCount", k), bus.wbCount, 32'(k));
            end
        end
        @(negedge clk);
        drive(1'b0, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd0);
        #1;
        check("wrap x3", bus.RFData1_ID, 32'd17);
        check("wrap lastWbAddr", {27'h0, bus.lastWbAddr}, 32'd3);
        check("wrap lastWbData", bus.lastWbData, 32'd17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
